// File: rtl/cordic_range_reduce.sv
// Range reduction for exp() via CORDIC: x = k*ln2 + r, so exp(x) = 2^k * exp(r).
// Optional k clamping to [K_MIN, K_MAX] with overflow flag under macro CORDIC_RR_SAT_EN.
module cordic_range_reduce #(
  parameter int unsigned INV_LN2 = 94548,
  parameter int unsigned LN2     = 45426,
  parameter int          K_MAX   = 15,
  parameter int          K_MIN   = -16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_angle,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_r,
  output logic [7:0]  out_k,
  output logic        out_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds data stable while valid=1 and ready=0, and valid never depends on ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] kraw_q, kraw_d;
  logic [31:0] r_q, r_d;
  logic [7:0]  k_q, k_d;
  logic        ovf_q, ovf_d;

  logic [63:0] prod;
  logic [63:0] prod_rnd;
  logic [31:0] k_sel;
  logic        ovf_sel;

  // Sign-extend x so the low 64 bits of the product are the signed result.
  assign prod     = {{32{x_q[31]}}, x_q} * 64'(INV_LN2);
  assign prod_rnd = prod + 64'h0000_0000_8000_0000;

`ifdef CORDIC_RR_SAT_EN
  always_comb begin
    k_sel   = kraw_q;
    ovf_sel = 1'b0;
    if ($signed(kraw_q) > K_MAX) begin
      k_sel   = 32'(K_MAX);
      ovf_sel = 1'b1;
    end else if ($signed(kraw_q) < K_MIN) begin
      k_sel   = 32'(K_MIN);
      ovf_sel = 1'b1;
    end
  end
`else
  assign k_sel   = kraw_q;
  assign ovf_sel = 1'b0;

  logic unused_k_lim;
  assign unused_k_lim = ^{K_MIN, K_MAX};
`endif

  logic unused_prod_lo;
  assign unused_prod_lo = ^prod_rnd[31:0];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    kraw_d  = kraw_q;
    r_d     = r_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_angle;
          state_d = MUL;
        end
      end
      MUL: begin
        kraw_d  = prod_rnd[63:32];
        state_d = SUB;
      end
      SUB: begin
        r_d     = x_q - k_sel * 32'(LN2);
        k_d     = k_sel[7:0];
        ovf_d   = ovf_sel;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      kraw_q  <= '0;
      r_q     <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      kraw_q  <= kraw_d;
      r_q     <= r_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_r     = r_q;
  assign out_k     = k_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Directed self-checking bench for cordic_range_reduce; expected values are hand-computed.
// Saturation expectations follow macro CORDIC_RR_SAT_EN.
module tb_cordic_range_reduce;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_angle = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_r;
  logic [7:0]  out_k;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  cordic_range_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_angle  (in_angle),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_r     (out_r),
    .out_k     (out_k),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    in_angle = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the handshake edge (cycle 1); returns the cycle out_valid rose.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_r !== 32'd0) begin errors++; $display("FAIL reset_out_r got %0d exp 0", out_r); end
    checks++; if (out_k !== 8'd0) begin errors++; $display("FAIL reset_out_k got %0d exp 0", out_k); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_vector(input string name, input int angle, input int exp_k,
                             input int exp_r, input logic exp_ovf);
    int cyc;
    out_ready = 1'b1;
    send(32'(angle));
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b exp 0", name, out_valid); end
    wait_valid(cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL %s_latency got %0d exp 3", name, cyc); end
    checks++; if (out_k !== 8'(exp_k)) begin errors++; $display("FAIL %s_k got %0d exp %0d", name, $signed(out_k), exp_k); end
    checks++; if (out_r !== 32'(exp_r)) begin errors++; $display("FAIL %s_r got %0d exp %0d", name, $signed(out_r), exp_r); end
    checks++; if (out_ovf !== exp_ovf) begin errors++; $display("FAIL %s_ovf got %b exp %b", name, out_ovf, exp_ovf); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_return_idle got valid=%b ready=%b exp valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_nominal();
    test_vector("nominal", -452200, -10, 2060, 1'b0);
  endtask

  task automatic test_boundaries();
    test_vector("zero", 0, 0, 0, 1'b0);
    test_vector("one", 65536, 1, 20110, 1'b0);
    test_vector("ten", 655360, 14, 19396, 1'b0);
  endtask

  task automatic test_saturation();
`ifdef CORDIC_RR_SAT_EN
    test_vector("sat", 1310720, 15, 629330, 1'b1);
`else
    test_vector("wrap", 1310720, 29, -6634, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    test_vector("b2b_a", 65536, 1, 20110, 1'b0);
    test_vector("b2b_b", -452200, -10, 2060, 1'b0);
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    send(32'd655360);
    wait_valid(cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", cyc); end
    in_angle = 32'd65536;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_k !== 8'd14 || out_r !== 32'd19396 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got valid=%b k=%0d r=%0d ready=%b exp valid=1 k=14 r=19396 ready=0",
                 i, out_valid, out_k, out_r, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    tick();
    tick();
    checks++; if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL bp_no_second got valid=%b state=%0d exp valid=0 state=0", out_valid, dbg_state);
    end
  endtask

  task automatic test_reset_abort();
    out_ready = 1'b1;
    send(32'd65536);
    tick();
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL abort_in_sub got state=%0d exp 2", dbg_state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_k !== 8'd0) begin
      errors++; $display("FAIL abort_next got valid=%b ready=%b k=%0d exp valid=0 ready=1 k=0", out_valid, in_ready, out_k);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_pulse cyc=%0d got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_priority();
    in_angle = 32'd65536;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rst_priority got ready=%b state=%0d exp ready=1 state=0", in_ready, dbg_state);
    end
    tick();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_priority_no_result got %b exp 0", out_valid); end
  endtask

  initial begin
    tick();
    test_reset();
    test_nominal();
    test_boundaries();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_range_reduce.md
CORDIC_RANGE_REDUCE -- requirements
Module: cordic_range_reduce

Interface
REQ-001 Parameter INV_LN2, default 94548, 1/ln2 in unsigned Q16.16.
REQ-002 Parameter LN2, default 45426, ln2 in unsigned Q16.16.
REQ-003 Parameter K_MAX, default 15, largest legal shift count k.
REQ-004 Parameter K_MIN, default -16, smallest legal shift count k.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_angle  in  32  signed Q16.16 argument x, same format as the CORDIC core's angle input.
REQ-008 in_valid  in  1  in_angle valid this cycle.
REQ-009 in_ready  out  1  block can accept an argument.
REQ-010 out_r  out  32  signed Q16.16 residual r = x - k*LN2, fed to the CORDIC core's angle input.
REQ-011 out_k  out  8  signed integer k, where exp(x) = 2^k * exp(r), for the downstream shifter.
REQ-012 out_ovf  out  1  k was clamped; present only with CORDIC_RR_SAT_EN, otherwise tied 0.
REQ-013 out_valid  out  1  out_r/out_k/out_ovf valid.
REQ-014 out_ready  in  1  consumer accepts the result.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, SUB, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE with in_valid=1, the block SHALL register in_angle and go to MUL; otherwise it stays in IDLE.
REQ-017 MUL SHALL form the signed 64-bit product P = x*INV_LN2 and k_raw = (P + 2^31) >>> 32 (arithmetic shift, round half toward +inf), then go to SUB.
REQ-018 SUB SHALL form r = x - k*LN2 in 32-bit two's complement, using the clamped k when saturation is enabled, then go to DONE.
REQ-019 In DONE, out_valid SHALL be 1, and out_r/out_k/out_ovf SHALL be held stable until out_ready=1.
REQ-020 A DONE cycle with out_ready=1 SHALL complete the transfer, drop out_valid next cycle, and return to IDLE.
REQ-021 Latency SHALL be 3 cycles from the in handshake to the first out_valid cycle; throughput SHALL be at most one result per 4 cycles.
REQ-022 in_valid during MUL, SUB or DONE SHALL be ignored, because in_ready=0.
REQ-023 out_ready asserted outside DONE SHALL have no effect.
REQ-024 out_k SHALL be the low 8 bits of k; with saturation disabled, k outside [-128,127] wraps silently.

Reset
REQ-025 With rst=1 at a clock edge, the FSM SHALL enter IDLE; out_valid, out_r, out_k and out_ovf SHALL be 0 and in_ready SHALL be 1 on the next cycle.
REQ-026 rst in MUL, SUB or DONE SHALL abort the operation and discard the result, with no out_valid pulse.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 With macro CORDIC_RR_SAT_EN defined, k_raw SHALL be clamped to [K_MIN, K_MAX], and out_ovf SHALL be 1 if and only if the clamp changed k.
REQ-029 With CORDIC_RR_SAT_EN undefined, k SHALL equal k_raw truncated to 8 bits, out_ovf SHALL be constant 0, and no clamp logic SHALL be present.

Verification
REQ-030 Reset: rst=1 for 2 cycles, then 0 -> out_valid=0, out_r=0, out_k=0, in_ready=1.
REQ-031 Nominal: in_angle=-452200 (-6.9) with out_ready=1 -> 3 cycles later out_k=-10, out_r=2060, out_ovf=0.
REQ-032 Boundaries, each with out_ready=1:
- in_angle=0 -> k=0, r=0.
- in_angle=65536 -> k=1, r=20110.
- in_angle=655360 -> k=14, r=19396.
REQ-033 Saturation, in_angle=1310720 (20.0): with CORDIC_RR_SAT_EN -> k=15, r=629330, out_ovf=1; without -> k=29, r=-6634, out_ovf=0.
REQ-034 Backpressure and reset: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, second in_valid ignored; then out_ready=1 -> one transfer, IDLE. A separate run asserts rst in SUB -> no out_valid and in_ready=1 next cycle.
